// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the IF/DM memory port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF   = 9;
  localparam int DATA_W_DEF   = 32;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} arb_state_t;
  typedef enum logic [1:0] {NONE, IF, DM} resp_owner_t;
endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive IF denials; promote lets IF win the next arbitration.
module arb_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  output logic promote
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = '0;
    if (if_req && !if_gnt)
      wait_cnt_d = (wait_cnt_q == MAX_C) ? wait_cnt_q : wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end

  assign promote = (wait_cnt_q == MAX_C);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-read memory between instruction fetch and data memory,
// with starvation promotion for IF and a halt/drain sequence.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              halt,
  output logic              stall_if,
  output logic              halted
);
  arb_state_t  state_q, state_d;
  resp_owner_t resp_owner_q, resp_owner_d;
  logic        promote, if_ok, dm_ok;

  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk     (clk),
    .rst     (reset),
    .if_req  (if_req),
    .if_gnt  (if_gnt),
    .promote (promote)
  );

  // IF is cut off in the very cycle halt is seen; DM keeps running until HALTED.
  assign if_ok  = !reset && (state_q == RUN) && !halt;
  assign dm_ok  = !reset && (state_q != HALTED);
  assign if_gnt = if_req && if_ok && (promote || !(dm_req && dm_ok));
  assign dm_gnt = dm_req && dm_ok && !if_gnt;

  assign mem_en    = if_gnt | dm_gnt;
  assign mem_we    = dm_gnt & dm_we;
  assign mem_addr  = dm_gnt ? dm_addr : if_addr;
  assign mem_wdata = dm_wdata;
  assign stall_if  = if_req & ~if_gnt;
  assign halted    = (state_q == HALTED);

  always_comb begin
    resp_owner_d = NONE;
    if (if_gnt)                resp_owner_d = IF;
    else if (dm_gnt && !dm_we) resp_owner_d = DM;
  end

  // Leaving DRAIN needs no new DM work and nothing recorded for next cycle; a response
  // already in flight this cycle is still delivered from resp_owner_q.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt) state_d = DRAIN;
      DRAIN:   if (!dm_req && resp_owner_d == NONE) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      resp_owner_q <= NONE;
    end else begin
      state_q      <= state_d;
      resp_owner_q <= resp_owner_d;
    end
  end

  assign if_rvalid = (resp_owner_q == IF);
  assign dm_rvalid = (resp_owner_q == DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9, memory word-address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MAX_WAIT, default 4, consecutive instruction-fetch (IF) denials before IF is promoted.
REQ-004 Clock and reset: clk in 1 (rising-edge clock); reset in 1 (asynchronous, active-high).
REQ-005 IF port: if_req in 1 (fetch request); if_addr in ADDR_W; if_gnt out 1; if_rvalid out 1; if_rdata out DATA_W.
REQ-006 Data-memory (DM) port: dm_req in 1; dm_we in 1 (1 = store, 0 = load); dm_addr in ADDR_W; dm_wdata in DATA_W; dm_gnt out 1; dm_rvalid out 1; dm_rdata out DATA_W.
REQ-007 Memory port: mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W (valid the cycle after a read is issued).
REQ-008 Control: halt in 1 (the decoded halt opcode has reached the execute stage); stall_if out 1; halted out 1.

Function
REQ-009 The block SHALL share one single-port, 1-cycle-read memory between the IF and DM requesters, issuing at most one access per cycle.
REQ-010 Grants are combinational from the current-cycle requests and state; mem_en = if_gnt | dm_gnt; if_gnt and dm_gnt are never both 1.
REQ-011 Default priority is DM over IF.
REQ-012 wait_cnt (width clog2(MAX_WAIT+1)) increments each cycle with if_req=1 and if_gnt=0, saturating at MAX_WAIT, and clears on if_gnt or when if_req=0.
REQ-013 When wait_cnt == MAX_WAIT, IF has priority over DM for that cycle.
REQ-014 Memory outputs follow the granted port: mem_addr, mem_we (= dm_we on DM grant, 0 on IF grant), and mem_wdata; the values when idle are don't-care, but mem_we = 0 whenever mem_en = 0.
REQ-015 A registered resp_owner {NONE, IF, DM} SHALL record each granted read.
REQ-016 In the following cycle, a read response asserts exactly one of if_rvalid or dm_rvalid for one cycle, with rdata = mem_rdata; the other port's rdata SHALL be held at 0.
REQ-017 A store produces no rvalid; its dm_gnt is its completion.
REQ-018 Back-to-back grants SHALL be allowed: a grant in cycle N and a response for cycle N-1 may coexist, giving full throughput.
REQ-019 stall_if = if_req & ~if_gnt.
REQ-020 The FSM has states RUN, DRAIN and HALTED.
REQ-021 RUN -> DRAIN on halt=1; from that cycle, if_gnt is forced to 0 while DM requests are still served.
REQ-022 DRAIN -> HALTED when dm_req=0 and resp_owner=NONE (no outstanding read).
REQ-023 In HALTED, halted=1, all grants are 0, and mem_en=0; HALTED is left only by reset.
REQ-024 halt asserted in the same cycle as a DM grant: the grant proceeds and the FSM enters DRAIN.
REQ-025 A response due in the cycle the FSM enters HALTED SHALL still be delivered.
REQ-026 Address pass-through uses no arithmetic; the wait counter SHALL never wrap.

Reset
REQ-027 Asynchronous reset SHALL force: state=RUN, wait_cnt=0, resp_owner=NONE, if_rvalid=0, dm_rvalid=0, if_rdata=0, dm_rdata=0, halted=0.
REQ-028 Because grants are combinational, if_gnt=dm_gnt=mem_en=0 while reset=1.
REQ-029 Reset asserted mid-read SHALL drop the pending response; no rvalid follows deassertion.
REQ-030 Requests held across reset deassertion SHALL be arbitrated normally in the first cycle after deassertion.

Structure
REQ-031 Package mem_arb_pkg SHALL hold: the arb_state_t enum {RUN, DRAIN, HALTED}; the resp_owner_t enum {NONE, IF, DM}; and default constants for ADDR_W, DATA_W and MAX_WAIT.
REQ-032 One sub-module, arb_wait_counter, SHALL implement the saturating starvation counter and its promote output; the FSM, grant logic and response steering live in the top module.

Verification
REQ-033 if_req=1 alone, addr 0x010, mem_rdata=0xDEADBEEF the next cycle -> if_gnt=1 in cycle N; if_rvalid=1 with if_rdata=0xDEADBEEF in N+1; dm_rvalid=0.
REQ-034 if_req=1 and dm_req=1 with a load at 0x020 in the same cycle -> dm_gnt=1, if_gnt=0, stall_if=1; dm_rvalid=1 in N+1.
REQ-035 dm_req=1 continuously with if_req=1 and MAX_WAIT=4 -> DM granted in cycles 0-3, IF granted in cycle 4, wait_cnt back to 0 in cycle 5, DM granted in cycle 5.
REQ-036 Store dm_we=1, addr 0x030, wdata 0x12345678 -> mem_en=1, mem_we=1, mem_addr=0x030, mem_wdata=0x12345678 in the same cycle; no dm_rvalid.
REQ-037 halt=1 during an outstanding IF read with one pending DM load -> if_rvalid is delivered; no further if_gnt; the DM load is granted; halted=1 one cycle after the last response.
REQ-038 reset pulsed in the cycle after a DM read grant -> dm_rvalid stays 0; all outputs at reset values; normal arbitration in the first cycle after deassertion.
